fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage: a decoupled fetch unit that owns the PC and issues one outstanding request at a time to the instruction cache interface.
- Each response is buffered with its PC in a DEPTH-entry queue, and the head is handed to decode over a valid/ready handshake.
- Handles pipeline redirects, including discarding in-flight responses, and halt detection.
- Absorbs variable cache latency, replacing the combinational stall/PC mux.

Parameters:
ADDR_WIDTH, 16, PC and cache address width
INSTR_WIDTH, 16, instruction width (must be >= 4)
DEPTH, 4, queue entries (>= 2, power of two)
PC_STEP, 2, PC increment per instruction
RESET_PC, 16'h0000, PC after reset
HALT_OPCODE, 4'hF, value of instr[INSTR_WIDTH-1 -: 4] that halts fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ic_req_valid  out  1  fetch request to instruction cache
ic_req_addr  out  ADDR_WIDTH  request address (= fetch_pc)
ic_req_ready  in  1  cache accepts the request this cycle
ic_resp_valid  in  1  response data valid
ic_resp_data  in  INSTR_WIDTH  returned instruction
redirect_valid  in  1  branch/disrupt redirect
redirect_pc  in  ADDR_WIDTH  redirect target
dec_valid  out  1  queue head valid
dec_instr  out  INSTR_WIDTH  head instruction
dec_pc  out  ADDR_WIDTH  head PC
dec_next_pc  out  ADDR_WIDTH  head PC + PC_STEP
dec_ready  in  1  decode consumes the head
occupancy  out  $clog2(DEPTH+1)  entries held
halted  out  1  a halt instruction has been fetched; fetch is stopped

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; state=FETCH; queue empty; drop=0.
- Outputs under reset: ic_req_valid=0, dec_valid=0, occupancy=0, halted=0.
- States: FETCH, WAIT, HALTED.
- FETCH:
  - ic_req_valid=1 iff occupancy<DEPTH and redirect_valid=0.
  - On ic_req_valid&ic_req_ready: go to WAIT.
- WAIT:
  - ic_req_valid=0.
  - On ic_resp_valid with drop=1: discard the data, clear drop, go to FETCH.
  - On ic_resp_valid with drop=0: push {fetch_pc, data}; fetch_pc += PC_STEP (wraps mod 2^ADDR_WIDTH).
  - After a push, go to HALTED if data[top 4 bits]==HALT_OPCODE, else FETCH.
- HALTED: ic_req_valid=0, halted=1. The queue continues draining to decode. Only a redirect exits this state.
- ic_resp_valid outside WAIT is ignored (covers stale responses after reset).
- Redirect has the highest priority and takes effect at the next edge:
  - Queue flushed; fetch_pc=redirect_pc; state=FETCH; halted clears.
  - From WAIT with no response this cycle: state stays WAIT with drop=1.
  - From WAIT with a response this cycle: that response is discarded, drop stays 0, state goes to FETCH.
  - A pop in the same cycle as a redirect is irrelevant (the flush wins).
- Queue:
  - Circular buffer with head/tail pointers.
  - dec_valid = occupancy!=0; dec_* are driven from the head entry combinationally.
  - Pop on dec_valid&dec_ready.
  - Simultaneous push and pop leaves occupancy unchanged; allowed at full.
  - No overflow is possible, because a request is issued only when a slot is free and at most one is outstanding.
- Latency:
  - Minimum 2 cycles from request accept to dec_valid: response at accept+1, entry visible after the push edge.
  - Back-to-back: one instruction per 2 cycles at zero cache latency.

Test Plan:
- Reset then run: RESET_PC=0, cache ready, 1-cycle responses of 16'h1000,16'h2000,16'h3000 with dec_ready=1 -> dec_pc sequence 0,2,4; dec_next_pc 2,4,6; instrs in order; occupancy never exceeds 1.
- Backpressure: dec_ready=0 -> exactly 4 entries accepted, occupancy=4, ic_req_valid=0. Assert dec_ready for 1 cycle -> one pop, then a single new request issues.
- Redirect in flight: request at PC 4 accepted; redirect_pc=16'h0040 with response delayed 3 cycles -> stale response discarded; next request addr=16'h0040; queue empty.
- Redirect same cycle as response -> response dropped, drop=0, next cycle ic_req_addr=redirect_pc.
- Halt: response 16'hF000 at PC 6 -> entry pushed, halted=1, no further ic_req_valid, queue drains. Redirect to 16'h0010 -> halted=0, fetch resumes at 16'h0010.
- Async reset asserted mid-WAIT with occupancy=3 -> all outputs 0 immediately. After release, a stray ic_resp_valid is ignored and the first request is at RESET_PC.
- PC wrap: redirect to 16'hFFFE, response -> dec_next_pc=16'h0000, next ic_req_addr=16'h0000.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch unit.
//
// Owns the fetch PC and issues one outstanding request at a time to the instruction cache.
// Each response is stored together with its PC in a DEPTH-entry circular queue. The queue
// head is offered to decode over a valid/ready handshake. A redirect flushes the queue,
// reloads the PC and discards any response still in flight. Fetching a halt instruction
// stops fetch until the next redirect.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   ic_req_valid/addr      request to the instruction cache (addr = fetch PC)
//   ic_req_ready           cache accepts the request this cycle
//   ic_resp_valid/data     cache response
//   redirect_valid/pc      pipeline redirect and its target
//   dec_valid/instr/pc     queue head offered to decode
//   dec_next_pc            head PC + PC_STEP
//   dec_ready              decode consumes the head
//   occupancy              number of queued entries
//   halted                 a halt instruction was fetched; fetch is stopped
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           PC_STEP     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ic_req_valid,
  output logic [ADDR_WIDTH-1:0]        ic_req_addr,
  input  logic                         ic_req_ready,
  input  logic                         ic_resp_valid,
  input  logic [INSTR_WIDTH-1:0]       ic_resp_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         dec_valid,
  output logic [INSTR_WIDTH-1:0]       dec_instr,
  output logic [ADDR_WIDTH-1:0]        dec_pc,
  output logic [ADDR_WIDTH-1:0]        dec_next_pc,
  input  logic                         dec_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHalted
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                    drop_q, drop_d;
  logic [PtrW-1:0]         head_q, head_d;
  logic [PtrW-1:0]         tail_q, tail_d;
  logic [CntW-1:0]         count_q, count_d;

  logic [ADDR_WIDTH-1:0]   pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0]  instr_mem_q [DEPTH];

  logic push;
  logic pop;
  logic is_halt;

  assign is_halt = (ic_resp_data[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  // Outputs. ic_req_valid is gated by rst so it stays low while reset is held.
  always_comb begin
    ic_req_valid = rst && (state_q == StFetch) && (count_q < CntW'(DEPTH)) && !redirect_valid;
    ic_req_addr  = fetch_pc_q;
    dec_valid    = (count_q != '0);
    dec_instr    = instr_mem_q[head_q];
    dec_pc       = pc_mem_q[head_q];
    dec_next_pc  = pc_mem_q[head_q] + ADDR_WIDTH'(PC_STEP);
    occupancy    = count_q;
    halted       = (state_q == StHalted);
  end

  // Next-state logic. A redirect overrides everything, including a same-cycle pop or push.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = dec_valid && dec_ready;

    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      if ((state_q == StWait) && !ic_resp_valid) begin
        // Request still in flight: wait for it and throw it away.
        state_d = StWait;
        drop_d  = 1'b1;
      end else begin
        // Any response arriving now belongs to the old stream and is consumed here.
        state_d = StFetch;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        StFetch: begin
          if (ic_req_valid && ic_req_ready) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (ic_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StFetch;
            end else begin
              push       = 1'b1;
              fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
              state_d    = is_halt ? StHalted : StFetch;
            end
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: begin
          state_d = StFetch;
        end
      endcase

      // Power-of-two depth lets the pointers wrap naturally.
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= ic_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a vector table for the basic fetch/decode flow, hand-written
// sequences for backpressure, redirect, halt, async reset and PC wrap, and a randomized
// run against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req_valid;
  logic [15:0] ic_req_addr;
  logic        ic_req_ready = 1'b0;
  logic        ic_resp_valid = 1'b0;
  logic [15:0] ic_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic [15:0] dec_next_pc;
  logic        dec_ready = 1'b0;
  logic [2:0]  occupancy;
  logic        halted;

  int checks = 0;
  int failures = 0;

  fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_req_ready  (ic_req_ready),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_data  (ic_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_next_pc   (dec_next_pc),
    .dec_ready     (dec_ready),
    .occupancy     (occupancy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        dec_rdy;
    logic        exp_req_valid;
    logic [15:0] exp_addr;
    logic        exp_dec_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_next;
    logic [2:0]  exp_occ;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  vec_t tbl[8];
  logic pend = 1'b0;
  int   seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_ready   = 1'b0;
    ic_resp_valid  = 1'b0;
    ic_resp_data   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("reset_req_valid", ic_req_valid, 0);
    chk("reset_dec_valid", dec_valid, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_halted", halted, 0);
    repeat (2) cycle();
    rst  = 1'b1;
    pend = 1'b0;
  endtask

  // Zero-latency cache: answers every accepted request on the following cycle.
  task automatic run_cache(input int n, input logic [15:0] base);
    logic fire;
    for (int i = 0; i < n; i++) begin
      ic_resp_valid = pend;
      ic_resp_data  = base + 16'(seq);
      if (pend) seq++;
      #1;
      fire = ic_req_valid && ic_req_ready;
      cycle();
      pend = fire;
    end
    ic_resp_valid = 1'b0;
  endtask

  initial begin
    // ---------------- table: reset then run ----------------
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h1000, 16'h0002,
               3'd1};
    tbl[3] = '{1'b1, 1'b1, 16'h2000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h2000, 16'h0004,
               3'd1};
    tbl[5] = '{1'b1, 1'b1, 16'h3000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'h3000, 16'h0006,
               3'd1};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      ic_req_ready  = tbl[i].req_ready;
      ic_resp_valid = tbl[i].resp_valid;
      ic_resp_data  = tbl[i].resp_data;
      dec_ready     = tbl[i].dec_rdy;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), ic_req_valid, tbl[i].exp_req_valid);
      if (tbl[i].exp_req_valid) chk($sformatf("tbl%0d_req_addr", i), ic_req_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_dec_valid", i), dec_valid, tbl[i].exp_dec_valid);
      if (tbl[i].exp_dec_valid) begin
        chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_dec_instr", i), dec_instr, tbl[i].exp_instr);
        chk($sformatf("tbl%0d_dec_next_pc", i), dec_next_pc, tbl[i].exp_next);
      end
      chk($sformatf("tbl%0d_occupancy", i), occupancy, tbl[i].exp_occ);
      cycle();
    end

    // ---------------- backpressure ----------------
    do_reset();
    seq = 0;
    ic_req_ready = 1'b1;
    dec_ready    = 1'b0;
    run_cache(8, 16'h1000);
    #1;
    chk("bp_full_occ", occupancy, 4);
    chk("bp_full_req_valid", ic_req_valid, 0);
    chk("bp_head_pc", dec_pc, 16'h0000);
    chk("bp_head_instr", dec_instr, 16'h1000);
    run_cache(2, 16'h1000);
    #1;
    chk("bp_still_full", occupancy, 4);
    dec_ready = 1'b1;
    #1;
    chk("bp_pop_valid", dec_valid, 1);
    cycle();
    dec_ready = 1'b0;
    #1;
    chk("bp_after_pop_occ", occupancy, 3);
    chk("bp_after_pop_req", ic_req_valid, 1);
    chk("bp_after_pop_addr", ic_req_addr, 16'h0008);
    chk("bp_after_pop_head", dec_pc, 16'h0002);
    run_cache(3, 16'h1000);
    #1;
    chk("bp_refill_occ", occupancy, 4);
    chk("bp_refill_req", ic_req_valid, 0);

    // ---------------- redirect while a request is in flight ----------------
    do_reset();
    ic_req_ready = 1'b1;
    dec_ready    = 1'b1;
    run_cache(4, 16'h2000);
    #1;
    chk("rif_req_addr", ic_req_addr, 16'h0004);
    chk("rif_req_valid", ic_req_valid, 1);
    cycle();
    ic_req_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    #1;
    chk("rif_redir_req", ic_req_valid, 0);
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rif_wait_req", ic_req_valid, 0);
      chk("rif_wait_occ", occupancy, 0);
      cycle();
    end
    ic_resp_valid = 1'b1;
    ic_resp_data  = 16'h1234;
    #1;
    chk("rif_stale_req", ic_req_valid, 0);
    cycle();
    ic_resp_valid = 1'b0;
    #1;
    chk("rif_new_req_valid", ic_req_valid, 1);
    chk("rif_new_req_addr", ic_req_addr, 16'h0040);
    chk("rif_queue_empty", dec_valid, 0);
    chk("rif_occ", occupancy, 0);

    // ---------------- redirect in the same cycle as a response ----------------
    do_reset();
    ic_req_ready = 1'b1;
    #1;
    chk("rsc_req_valid", ic_req_valid, 1);
    cycle();
    ic_req_ready   = 1'b0;
    ic_resp_valid  = 1'b1;
    ic_resp_data   = 16'h1111;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    cycle();
    ic_resp_valid  = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rsc_req_valid2", ic_req_valid, 1);
    chk("rsc_req_addr", ic_req_addr, 16'h0080);
    chk("rsc_occ", occupancy, 0);
    ic_req_ready = 1'b1;
    cycle();
    ic_req_ready  = 1'b0;
    ic_resp_valid = 1'b1;
    ic_resp_data  = 16'h2222;
    cycle();
    ic_resp_valid = 1'b0;
    #1;
    chk("rsc_push_valid", dec_valid, 1);
    chk("rsc_push_pc", dec_pc, 16'h0080);
    chk("rsc_push_instr", dec_instr, 16'h2222);

    // ---------------- halt ----------------
    do_reset();
    ic_req_ready = 1'b1;
    dec_ready    = 1'b0;
    run_cache(6, 16'h3000);
    #1;
    chk("halt_req_addr", ic_req_addr, 16'h0006);
    chk("halt_req_valid", ic_req_valid, 1);
    cycle();
    ic_req_ready  = 1'b0;
    ic_resp_valid = 1'b1;
    ic_resp_data  = 16'hF000;
    cycle();
    ic_resp_valid = 1'b0;
    ic_req_ready  = 1'b1;
    #1;
    chk("halt_halted", halted, 1);
    chk("halt_req_off", ic_req_valid, 0);
    chk("halt_occ", occupancy, 4);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halt_drain_req", ic_req_valid, 0);
      chk("halt_drain_halted", halted, 1);
      if (i == 3) begin
        chk("halt_last_pc", dec_pc, 16'h0006);
        chk("halt_last_instr", dec_instr, 16'hF000);
      end
      cycle();
    end
    #1;
    chk("halt_drained", dec_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("halt_exit", halted, 0);
    chk("halt_resume_req", ic_req_valid, 1);
    chk("halt_resume_addr", ic_req_addr, 16'h0010);

    // ---------------- async reset mid-WAIT ----------------
    do_reset();
    ic_req_ready = 1'b1;
    dec_ready    = 1'b0;
    run_cache(6, 16'h4000);
    #1;
    chk("ar_occ3", occupancy, 3);
    chk("ar_req", ic_req_valid, 1);
    cycle();
    ic_req_ready = 1'b0;
    #1;
    chk("ar_wait_req", ic_req_valid, 0);
    rst = 1'b0;
    #1;
    chk("ar_req_valid", ic_req_valid, 0);
    chk("ar_dec_valid", dec_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_halted", halted, 0);
    cycle();
    rst           = 1'b1;
    ic_resp_valid = 1'b1;
    ic_resp_data  = 16'hF000;
    #1;
    chk("ar_first_req", ic_req_valid, 1);
    chk("ar_first_addr", ic_req_addr, 16'h0000);
    cycle();
    ic_resp_valid = 1'b0;
    #1;
    chk("ar_stray_occ", occupancy, 0);
    chk("ar_stray_halted", halted, 0);
    chk("ar_stray_req", ic_req_valid, 1);
    chk("ar_stray_addr", ic_req_addr, 16'h0000);

    // ---------------- PC wrap ----------------
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cycle();
    redirect_valid = 1'b0;
    ic_req_ready   = 1'b1;
    #1;
    chk("wrap_req_addr", ic_req_addr, 16'hFFFE);
    cycle();
    ic_req_ready  = 1'b0;
    ic_resp_valid = 1'b1;
    ic_resp_data  = 16'h1ABC;
    cycle();
    ic_resp_valid = 1'b0;
    #1;
    chk("wrap_dec_pc", dec_pc, 16'hFFFE);
    chk("wrap_dec_next_pc", dec_next_pc, 16'h0000);
    chk("wrap_req_valid", ic_req_valid, 1);
    chk("wrap_next_addr", ic_req_addr, 16'h0000);

    // ---------------- randomized run against the reference model ----------------
    begin
      entry_t      mq[$];
      entry_t      e;
      logic [15:0] m_pc;
      logic        m_out;
      logic        m_disc;
      logic        m_halt;
      logic        c_pend;
      int          c_lat;
      logic        exp_rv;
      logic        fire;
      logic        do_pop;

      do_reset();
      m_pc   = 16'h0000;
      m_out  = 1'b0;
      m_disc = 1'b0;
      m_halt = 1'b0;
      c_pend = 1'b0;
      c_lat  = 0;
      for (int n = 0; n < 4000; n++) begin
        ic_req_ready   = ($urandom % 4) != 0;
        dec_ready      = ($urandom % 3) != 0;
        redirect_valid = ($urandom % 25) == 0;
        redirect_pc    = 16'($urandom_range(0, 65535)) & 16'hFFFE;
        if (c_pend) ic_resp_valid = (c_lat == 0);
        else        ic_resp_valid = ($urandom % 16) == 0;
        ic_resp_data = 16'($urandom_range(0, 65535));
        #1;

        exp_rv = !m_out && !m_halt && (mq.size() < 4) && !redirect_valid;
        chk("rnd_req_valid", ic_req_valid, exp_rv);
        if (exp_rv) chk("rnd_req_addr", ic_req_addr, m_pc);
        chk("rnd_dec_valid", dec_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("rnd_dec_pc", dec_pc, mq[0].pc);
          chk("rnd_dec_instr", dec_instr, mq[0].instr);
          chk("rnd_dec_next_pc", dec_next_pc, mq[0].pc + 16'd2);
        end
        chk("rnd_occupancy", occupancy, mq.size());
        chk("rnd_halted", halted, m_halt);

        // Cache side: one response per accepted request, 0..3 extra cycles later.
        fire = exp_rv && ic_req_ready;
        if (c_pend) begin
          if (c_lat == 0) c_pend = 1'b0;
          else            c_lat--;
        end
        if (fire) begin
          c_pend = 1'b1;
          c_lat  = $urandom_range(0, 3);
        end

        // Reference model update.
        do_pop = (mq.size() != 0) && dec_ready;
        if (redirect_valid) begin
          mq.delete();
          m_pc   = redirect_pc;
          m_halt = 1'b0;
          if (m_out) begin
            if (ic_resp_valid) begin
              m_out  = 1'b0;
              m_disc = 1'b0;
            end else begin
              m_disc = 1'b1;
            end
          end
        end else begin
          if (do_pop) void'(mq.pop_front());
          if (fire) begin
            m_out = 1'b1;
          end else if (m_out && ic_resp_valid) begin
            m_out = 1'b0;
            if (m_disc) begin
              m_disc = 1'b0;
            end else begin
              e.pc    = m_pc;
              e.instr = ic_resp_data;
              mq.push_back(e);
              m_pc = m_pc + 16'd2;
              if (ic_resp_data[15:12] == 4'hF) m_halt = 1'b1;
            end
          end
        end
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
